instr_fetch_queue: RTL
======================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 32'h0, as the first fetch address after reset.
REQ-002 The block SHALL take parameter DEPTH, default 2 (legal 2..8), as the number of instruction queue entries.
REQ-003 The block SHALL have port clock  in  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  in  1  synchronous active-high reset.
REQ-005 The block SHALL have port redirect  in  1  branch/jump taken; restart fetch at redirectPc.
REQ-006 The block SHALL have port redirectPc  in  32  new fetch address.
REQ-007 The block SHALL have port memReq  out  1  fetch request to instruction memory.
REQ-008 The block SHALL have port memAddr  out  32  fetch address; equals fetchPc at all times.
REQ-009 The block SHALL have port memAck  in  1  memory accepted the request this cycle.
REQ-010 The block SHALL have port memValid  in  1  memData carries the response this cycle.
REQ-011 The block SHALL have port memData  in  32  fetched instruction word.
REQ-012 The block SHALL have port instrValid  out  1  queue head is valid.
REQ-013 The block SHALL have port instr  out  32  instruction at queue head.
REQ-014 The block SHALL have port pcQ  out  32  address of the instruction at queue head.
REQ-015 The block SHALL have port instrReady  in  1  datapath consumes the head this cycle.

Function
REQ-016 The block SHALL implement FSM states IDLE, REQ, WAIT and DROP, with at most one memory transaction outstanding.
REQ-017 IDLE SHALL go to REQ when count < DEPTH; otherwise IDLE SHALL be held.
REQ-018 In REQ, memReq SHALL be 1 and memAddr SHALL be held stable until memAck.
REQ-019 REQ SHALL go to WAIT on memAck, and fetchPc SHALL advance by 4 on that edge.
REQ-020 WAIT SHALL go to IDLE on memValid and push {fetch address, memData} into the queue.
REQ-021 fetchPc SHALL wrap modulo 2^32: 32'hFFFFFFFC + 4 = 32'h0.
REQ-022 memValid outside WAIT or DROP SHALL be ignored.
REQ-023 The queue SHALL be FIFO: instrValid = (count != 0); instr and pcQ show the head; the head is popped when instrValid and instrReady.
REQ-024 A push and a pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-025 A request SHALL be issued only if count plus outstanding is below DEPTH, so a push never meets a full queue.
REQ-026 redirect SHALL have priority over every other event in its cycle.
REQ-027 On redirect, the block SHALL flush the queue (count=0), ignore the pop, and load fetchPc = {redirectPc[31:2], 2'b00}.
REQ-028 On redirect in WAIT, or in REQ with memAck the same cycle, the state SHALL go to DROP; the next memValid is discarded and the state then goes to IDLE.
REQ-029 On redirect in IDLE, or in REQ without memAck, the state SHALL go to IDLE.
REQ-030 On redirect in DROP, the state SHALL stay in DROP.
REQ-031 On redirect in WAIT with memValid the same cycle, the data SHALL be discarded and the state SHALL go to IDLE.
REQ-032 instrValid SHALL be 0 in the cycle after any redirect.

Reset
REQ-033 With reset=1 at a clock edge, the block SHALL set state=IDLE, fetchPc=RESET_PC, count=0 and clear the drop flag; reset overrides redirect.
REQ-034 During and immediately after reset, memReq=0, instrValid=0, memAddr=RESET_PC, and instr and pcQ SHALL read 32'h0.
REQ-035 Reset asserted mid-transaction SHALL abandon it; a later stray memValid SHALL be ignored because the state is IDLE.

Verification
REQ-036 Cold start with memory latency 1 and instrReady=1 -> memAddr 0,4,8,...; pcQ/instr stream in order, with no duplicates or gaps.
REQ-037 instrReady=0, DEPTH=2 -> exactly two entries (pc 0,4); memReq stays 0 until a pop; then the next request goes to 8.
REQ-038 Redirect to 32'h100 while in WAIT for pc 8 -> the stale response is dropped; the first pcQ after redirect is 32'h100.
REQ-039 Redirect with redirectPc=32'h203 -> memAddr becomes 32'h200.
REQ-040 RESET_PC=32'hFFFFFFFC -> pcQ sequence FFFFFFFC, 00000000, 00000004.
REQ-041 Reset pulse while in REQ with memAck held 0 -> memReq drops, then reissues at RESET_PC; a stray memValid is ignored.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: sequential fetch FSM with at most one outstanding memory
// transaction, feeding a small in-order instruction queue that is flushed on redirect.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic        memValid,
    input  logic [31:0] memData,
    output logic        instrValid,
    output logic [31:0] instr,
    output logic [31:0] pcQ,
    input  logic        instrReady
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_fetch_pc;
    logic [31:0]       w_fetch_pc_nxt;
    logic [31:0]       r_req_pc;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [31:0]       r_pc_mem    [DEPTH];
    logic [31:0]       r_instr_mem [DEPTH];
    logic              w_push;
    logic              w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    // Only IDLE issues requests and it has nothing outstanding, so count < DEPTH
    // there guarantees the eventual push finds a free slot.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_push         = 1'b0;
        case (r_state)
            IDLE: if (r_count < DEPTH_C) w_state_nxt = REQ;
            REQ: begin
                if (memAck) begin
                    w_state_nxt    = WAIT;
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                end
            end
            WAIT: begin
                if (memValid) begin
                    w_state_nxt = IDLE;
                    w_push      = 1'b1;
                end
            end
            DROP: if (memValid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        // Any transaction still in flight after a redirect must be drained through DROP.
        if (redirect) begin
            w_push         = 1'b0;
            w_fetch_pc_nxt = redirectPc & 32'hFFFF_FFFC;
            case (r_state)
                IDLE:    w_state_nxt = IDLE;
                REQ:     w_state_nxt = memAck   ? DROP : IDLE;
                WAIT:    w_state_nxt = memValid ? IDLE : DROP;
                DROP:    w_state_nxt = memValid ? IDLE : DROP;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_pop = instrValid && instrReady && !redirect;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            if (r_state == REQ && memAck) r_req_pc <= r_fetch_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || redirect) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // NOTE: queue storage has no reset; entries are only visible once counted, and outputs are masked while empty.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_req_pc;
            r_instr_mem[r_wr_ptr] <= memData;
        end
    end

    assign memReq     = (r_state == REQ);
    assign memAddr    = r_fetch_pc;
    assign instrValid = (r_count != '0);
    assign instr      = instrValid ? r_instr_mem[r_rd_ptr] : 32'h0;
    assign pcQ        = instrValid ? r_pc_mem[r_rd_ptr]    : 32'h0;

endmodule
